// File: rtl/path_mux_n_if.sv
// Producer/consumer bundle for path_mux_n.
// The slave modport is the mux; the master side drives the producers and the consumer grant.
interface path_mux_n_if #(
  parameter int DWIDTH = 8,
  parameter int NCH    = 4,
  parameter int FDEPTH = 5,
  parameter int CW     = $clog2(NCH),
  parameter int FW     = $clog2(FDEPTH + 1)
);
  logic [NCH*DWIDTH-1:0] data_i;
  logic [NCH-1:0]        valid_i;
  logic [NCH-1:0]        stop_o;
  logic                  req_o;
  logic                  gnt_i;
  logic [DWIDTH-1:0]     data_o;
  logic [CW-1:0]         ch_o;
  logic                  valid_o;
  logic [FW-1:0]         fill_o;

  modport slave (
    input  data_i, valid_i, gnt_i,
    output stop_o, req_o, data_o, ch_o, valid_o, fill_o
  );

  modport master (
    output data_i, valid_i, gnt_i,
    input  stop_o, req_o, data_o, ch_o, valid_o, fill_o
  );
endinterface

// File: rtl/path_mux_n.sv
// N-channel round-robin burst mux with an FDEPTH-entry FIFO and a bypass path.
// Output words carry their source channel; idle channels can be skipped at burst boundaries.
module path_mux_n #(
  parameter int DWIDTH    = 8,
  parameter int FDEPTH    = 5,
  parameter int NCH       = 4,
  parameter int BURST     = 10,
  parameter int SKIP_IDLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  path_mux_n_if.slave bus
);
  localparam int CW = $clog2(NCH);
  localparam int FW = $clog2(FDEPTH + 1);
  localparam int PW = $clog2(FDEPTH);
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  logic [CW+DWIDTH-1:0] mem_q [FDEPTH];
  logic [PW-1:0]        rd_q, rd_d;
  logic [PW-1:0]        wr_q, wr_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [CW-1:0]        cur_q, cur_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0]    data_q, data_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic                 vld_q, vld_d;

  logic [DWIDTH-1:0] cur_word;
  logic [NCH-1:0]    stop;
  logic [CW-1:0]     cur_inc;
  logic cur_vld, oth_vld;
  logic empty, full, rd_en, stall;
  logic accept, bypass, wr_en;

  always_comb begin
    cur_word = '0;
    cur_vld  = 1'b0;
    oth_vld  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (CW'(k) == cur_q) begin
        cur_word = bus.data_i[k*DWIDTH +: DWIDTH];
        cur_vld  = bus.valid_i[k];
      end else begin
        oth_vld  = oth_vld | bus.valid_i[k];
      end
    end
  end

  assign empty   = (fill_q == '0);
  assign full    = (fill_q == FW'(FDEPTH));
  assign rd_en   = !empty && bus.gnt_i;
  assign stall   = full && !rd_en;
  assign accept  = cur_vld && !stall;
  assign bypass  = empty && bus.gnt_i && accept;
  assign wr_en   = accept && !bypass;
  assign cur_inc = (cur_q == CW'(NCH-1)) ? '0 : cur_q + 1'b1;

  always_comb begin
    stop = '0;
    for (int k = 0; k < NCH; k++) begin
      stop[k] = stall || (CW'(k) != cur_q);
    end
  end

  assign bus.stop_o  = stop;
  assign bus.req_o   = !empty || accept;
  assign bus.data_o  = data_q;
  assign bus.ch_o    = ch_q;
  assign bus.valid_o = vld_q;
  assign bus.fill_o  = fill_q;

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    fill_d = fill_q + FW'(wr_en) - FW'(rd_en);
    if (rd_en) rd_d = (rd_q == PW'(FDEPTH-1)) ? '0 : rd_q + 1'b1;
    if (wr_en) wr_d = (wr_q == PW'(FDEPTH-1)) ? '0 : wr_q + 1'b1;
  end

  // Skipping only happens at a burst boundary and never while stalled.
  always_comb begin
    cur_d = cur_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (cnt_q == BW'(BURST-1)) begin
        cnt_d = '0;
        cur_d = cur_inc;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if ((SKIP_IDLE != 0) && (cnt_q == '0) &&
                 !cur_vld && oth_vld && !stall) begin
      cur_d = cur_inc;
    end
  end

  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    vld_d  = 1'b0;
    if (bypass) begin
      data_d = cur_word;
      ch_d   = cur_q;
      vld_d  = 1'b1;
    end else if (rd_en) begin
      {ch_d, data_d} = mem_q[rd_q];
      vld_d          = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {cur_q, cur_word};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      fill_q <= '0;
      cur_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      fill_q <= fill_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
    end
  end
endmodule

// File: tb/tb_path_mux_n.sv
// Scoreboard bench for path_mux_n: directed words queue their expected output,
// a negedge monitor pops and compares every valid_o pulse.
module tb_path_mux_n;
  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int FD  = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int d;
  } exp_t;
  exp_t exp_q[$];

  path_mux_n_if #(.DWIDTH(DW), .NCH(NCH), .FDEPTH(FD)) bus ();
  path_mux_n_if #(.DWIDTH(DW), .NCH(NCH), .FDEPTH(FD)) bus2 ();

  path_mux_n #(
    .DWIDTH(DW), .FDEPTH(FD), .NCH(NCH), .BURST(10), .SKIP_IDLE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  path_mux_n #(
    .DWIDTH(DW), .FDEPTH(FD), .NCH(NCH), .BURST(10), .SKIP_IDLE(0)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", nm, got, req);
    end
  endfunction

  function automatic void expect_w(int ch, int d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", int'(bus.data_o), -1);
      end else begin
        e = exp_q.pop_front();
        chk("out_ch", int'(bus.ch_o), e.ch);
        chk("out_data", int'(bus.data_o), e.d);
      end
    end
  end

  // Present one word on channel ch and hold it until the edge that accepts it.
  task automatic send(input int ch, input int d);
    int n;
    n = 0;
    bus.data_i = '0;
    bus.data_i[ch*DW +: DW] = DW'(d);
    bus.valid_i = NCH'(1 << ch);
    #1;
    while (bus.stop_o[ch] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    @(negedge clk);
    bus.valid_i = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.fill_o != '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", int'(bus.fill_o), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.valid_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.data_i   = '0;
    bus.valid_i  = '0;
    bus.gnt_i    = 1'b0;
    bus2.data_i  = 32'hAA00_0000;
    bus2.valid_i = 4'b1000;
    bus2.gnt_i   = 1'b1;

    do_reset();
    #1;
    chk("rst_fill", int'(bus.fill_o), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_data", int'(bus.data_o), 0);
    chk("rst_ch", int'(bus.ch_o), 0);
    chk("rst_stop", int'(bus.stop_o), 4'b1110);
    chk("rst_req", int'(bus.req_o), 0);

    // 1: bypass burst on ch0
    bus.gnt_i = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      expect_w(0, i);
      send(0, i);
      chk("t1_latency", int'(bus.valid_o), 1);
      chk("t1_fill", int'(bus.fill_o), 0);
    end
    #1;
    chk("t1_stop_after", int'(bus.stop_o), 4'b1101);

    // 2: fill the FIFO on ch1, then release
    bus.gnt_i = 1'b0;
    for (int i = 1; i <= 7; i++) expect_w(1, 'h20 + i);
    for (int i = 1; i <= 5; i++) send(1, 'h20 + i);
    bus.data_i = '0;
    bus.data_i[1*DW +: DW] = 8'h26;
    bus.valid_i = 4'b0010;
    #1;
    chk("t2_full", int'(bus.fill_o), 5);
    chk("t2_stop_full", int'(bus.stop_o), 4'b1111);
    @(negedge clk);
    #1;
    chk("t2_stop_hold", int'(bus.stop_o), 4'b1111);
    chk("t2_fill_hold", int'(bus.fill_o), 5);
    bus.gnt_i = 1'b1;
    #1;
    chk("t2_stop_rel", int'(bus.stop_o), 4'b1101);
    chk("t2_req", int'(bus.req_o), 1);
    @(negedge clk);
    send(1, 'h27);
    drain();

    // 3: full FIFO streaming one in / one out
    bus.gnt_i = 1'b0;
    for (int i = 1; i <= 3; i++) expect_w(1, 'h30 + i);
    for (int i = 4; i <= 9; i++) expect_w(2, 'h30 + i);
    for (int i = 1; i <= 3; i++) send(1, 'h30 + i);
    send(2, 'h34);
    send(2, 'h35);
    bus.gnt_i = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      bus.data_i = '0;
      bus.data_i[2*DW +: DW] = DW'('h30 + i);
      bus.valid_i = 4'b0100;
      #1;
      chk("t3_stop", int'(bus.stop_o), 4'b1011);
      @(negedge clk);
      chk("t3_fill", int'(bus.fill_o), 5);
    end
    bus.valid_i = '0;
    drain();

    // 4: skip idle channels from a fresh burst boundary
    do_reset();
    bus.gnt_i = 1'b1;
    bus.data_i = '0;
    bus.data_i[3*DW +: DW] = 8'h41;
    bus.valid_i = 4'b1000;
    #1;
    chk("t4_stop0", int'(bus.stop_o), 4'b1110);
    chk("t4_req0", int'(bus.req_o), 0);
    @(negedge clk);
    #1;
    chk("t4_stop1", int'(bus.stop_o), 4'b1101);
    chk("t4_noskip_stop", int'(bus2.stop_o), 4'b1110);
    @(negedge clk);
    #1;
    chk("t4_stop2", int'(bus.stop_o), 4'b1011);
    @(negedge clk);
    #1;
    chk("t4_stop3", int'(bus.stop_o), 4'b0111);
    chk("t4_req3", int'(bus.req_o), 1);
    chk("t4_noskip_stop3", int'(bus2.stop_o), 4'b1110);
    chk("t4_noskip_req", int'(bus2.req_o), 0);
    expect_w(3, 'h41);
    @(negedge clk);
    chk("t4_ch", int'(bus.ch_o), 3);
    bus.valid_i = '0;

    // 5: mid-burst idle holds cur/cnt even with another channel valid
    for (int i = 2; i <= 4; i++) begin
      expect_w(3, 'h40 + i);
      send(3, 'h40 + i);
    end
    bus.data_i = '0;
    bus.data_i[0 +: DW] = 8'h99;
    bus.valid_i = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_idle_stop", int'(bus.stop_o), 4'b0111);
      chk("t5_idle_req", int'(bus.req_o), 0);
      @(negedge clk);
    end
    for (int i = 5; i <= 10; i++) begin
      expect_w(3, 'h40 + i);
      send(3, 'h40 + i);
    end
    #1;
    chk("t5_burst_end", int'(bus.stop_o), 4'b1110);
    drain();

    // 6: reset discards buffered words
    bus.gnt_i = 1'b0;
    for (int i = 1; i <= 3; i++) send(0, 'h60 + i);
    #1;
    chk("t6_fill3", int'(bus.fill_o), 3);
    chk("t6_req", int'(bus.req_o), 1);
    do_reset();
    #1;
    chk("t6_fill", int'(bus.fill_o), 0);
    chk("t6_valid", int'(bus.valid_o), 0);
    chk("t6_data", int'(bus.data_o), 0);
    chk("t6_ch", int'(bus.ch_o), 0);
    chk("t6_req0", int'(bus.req_o), 0);
    bus.gnt_i = 1'b1;
    repeat (6) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    chk("noskip_fill", int'(bus2.fill_o), 0);
    chk("noskip_valid", int'(bus2.valid_o), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
